// File: rtl/bp_me_cce_block_to_dword_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : bp_me_cce_block_to_dword_stream_if
// Description : Command/response link with valid/ready commands and
//               valid/yumi responses; shared by the block and dword sides.
// Revision    : 1.0 - initial release
// ============================================================================
interface bp_me_cce_block_to_dword_stream_if #(
    parameter int HDR_WIDTH  = 47,
    parameter int DATA_WIDTH = 64
);
    logic [HDR_WIDTH-1:0]  cmd_header;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  cmd_v;
    logic                  cmd_ready;
    logic                  cmd_lock;
    logic [HDR_WIDTH-1:0]  resp_header;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_v;
    logic                  resp_yumi;
    logic                  resp_lock;

    modport master (
        output cmd_header, cmd_data, cmd_v, cmd_lock,
        input  cmd_ready,
        input  resp_header, resp_data, resp_v, resp_lock,
        output resp_yumi
    );

    modport slave (
        input  cmd_header, cmd_data, cmd_v, cmd_lock,
        output cmd_ready,
        output resp_header, resp_data, resp_v, resp_lock,
        input  resp_yumi
    );
endinterface
`default_nettype wire

// File: rtl/bp_me_cce_block_to_dword_stream.sv
`default_nettype none
// ============================================================================
// Module      : bp_me_cce_block_to_dword_stream
// Description : Splits a block memory command into locked dword beats and
//               reassembles the per-beat responses into one block response.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_me_cce_block_to_dword_stream #(
    parameter int PADDR_WIDTH = 40,
    parameter int BLOCK_WIDTH = 512,
    parameter int DWORD_WIDTH = 64
) (
    input  wire logic                          clk_i,
    input  wire logic                          reset_i,
    bp_me_cce_block_to_dword_stream_if.slave   mem,
    bp_me_cce_block_to_dword_stream_if.master  stream
);
    localparam int c_beats    = BLOCK_WIDTH / DWORD_WIDTH;
    localparam int c_word_w   = $clog2(c_beats);
    localparam int c_cnt_w    = c_word_w + 1;
    localparam int c_byte_off = $clog2(DWORD_WIDTH / 8);
    localparam int c_hdr_w    = PADDR_WIDTH + 7;
    localparam int c_size_lsb = PADDR_WIDTH;
    localparam logic [2:0] c_size_dword = 3'(c_byte_off);

    typedef enum logic [1:0] {
        e_ready = 2'd0,
        e_busy  = 2'd1,
        e_resp  = 2'd2
    } state_e;

    state_e                   r_state, w_state_nxt;
    logic [c_hdr_w-1:0]       r_cmd_header;
    logic [BLOCK_WIDTH-1:0]   r_cmd_data;
    logic [BLOCK_WIDTH-1:0]   r_resp_data;
    logic [c_cnt_w-1:0]       r_n_beats, r_cmd_cnt, r_resp_cnt;
    logic [c_cnt_w-1:0]       w_n_beats, w_cmd_cnt_nxt, w_resp_cnt_nxt;
    logic [2:0]               w_cmd_size;
    logic                     w_cmd_accept, w_beat_fire, w_resp_fire;

    // Multi-beat commands walk the block critical-word-first, wrapping at the block boundary.
    function automatic logic [c_hdr_w-1:0] f_beat_header(
        input logic [c_hdr_w-1:0]  hdr,
        input logic [c_cnt_w-1:0]  n_beats,
        input logic [c_word_w-1:0] idx
    );
        logic [c_hdr_w-1:0] beat;
        beat = hdr;
        if (n_beats > c_cnt_w'(1)) begin
            beat[c_byte_off +: c_word_w] = hdr[c_byte_off +: c_word_w] + idx;
            beat[c_byte_off-1:0]         = '0;
            beat[c_size_lsb +: 3]        = c_size_dword;
        end
        return beat;
    endfunction

    assign w_cmd_size = mem.cmd_header[c_size_lsb +: 3];

    always_comb begin
        w_n_beats = c_cnt_w'(1);
        if (w_cmd_size > c_size_dword) begin
            if ((w_cmd_size - c_size_dword) >= 3'(c_word_w)) begin
                w_n_beats = c_cnt_w'(c_beats);
            end else begin
                w_n_beats = c_cnt_w'(1) << (w_cmd_size - c_size_dword);
            end
        end
    end

    assign mem.cmd_ready     = (r_state == e_ready) & ~reset_i;
    assign w_cmd_accept      = mem.cmd_v & mem.cmd_ready;
    assign mem.resp_v        = (r_state == e_resp);
    assign mem.resp_header   = r_cmd_header;
    assign mem.resp_data     = r_resp_data;
    assign mem.resp_lock     = 1'b0;

    assign stream.cmd_v      = (r_state == e_busy) && (r_cmd_cnt < r_n_beats);
    assign stream.cmd_header = f_beat_header(r_cmd_header, r_n_beats, r_cmd_cnt[c_word_w-1:0]);
    assign stream.cmd_data   = r_cmd_data[r_cmd_cnt[c_word_w-1:0]*DWORD_WIDTH +: DWORD_WIDTH];
    assign stream.cmd_lock   = stream.cmd_v && (r_cmd_cnt != (r_n_beats - c_cnt_w'(1)));
    assign w_beat_fire       = stream.cmd_v & stream.cmd_ready;

    assign stream.resp_yumi  = (r_state == e_busy) & stream.resp_v;
    assign w_resp_fire       = stream.resp_yumi;

    assign w_cmd_cnt_nxt     = r_cmd_cnt + c_cnt_w'(w_beat_fire);
    assign w_resp_cnt_nxt    = r_resp_cnt + c_cnt_w'(w_resp_fire);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= e_ready;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            e_ready: if (w_cmd_accept) w_state_nxt = e_busy;
            e_busy:  if ((w_cmd_cnt_nxt == r_n_beats) && (w_resp_cnt_nxt == r_n_beats))
                         w_state_nxt = e_resp;
            e_resp:  if (mem.resp_yumi) w_state_nxt = e_ready;
            default: w_state_nxt = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cmd_header <= '0;
            r_cmd_data   <= '0;
            r_resp_data  <= '0;
            r_n_beats    <= '0;
            r_cmd_cnt    <= '0;
            r_resp_cnt   <= '0;
        end else begin
            if (w_cmd_accept) begin
                r_cmd_header <= mem.cmd_header;
                r_cmd_data   <= mem.cmd_data;
                r_n_beats    <= w_n_beats;
                r_cmd_cnt    <= '0;
                r_resp_cnt   <= '0;
            end else begin
                r_cmd_cnt    <= w_cmd_cnt_nxt;
                r_resp_cnt   <= w_resp_cnt_nxt;
            end
            // A single-beat response fills every slot so any dword of the block reads it back.
            if (w_resp_fire) begin
                if (r_n_beats == c_cnt_w'(1)) begin
                    for (int i = 0; i < c_beats; i++) begin
                        r_resp_data[i*DWORD_WIDTH +: DWORD_WIDTH] <= stream.resp_data;
                    end
                end else begin
                    r_resp_data[r_resp_cnt[c_word_w-1:0]*DWORD_WIDTH +: DWORD_WIDTH] <= stream.resp_data;
                end
            end
        end
    end

    a_resp_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        w_resp_fire |-> (r_resp_cnt < r_n_beats));
    a_resp_lock: assert property (@(posedge clk_i) disable iff (reset_i)
        (w_resp_fire && (r_resp_cnt != (r_n_beats - c_cnt_w'(1)))) |-> stream.resp_lock);
    a_resp_header: assert property (@(posedge clk_i) disable iff (reset_i)
        w_resp_fire |-> (stream.resp_header ==
                         f_beat_header(r_cmd_header, r_n_beats, r_resp_cnt[c_word_w-1:0])));
    a_block_cmd_unlocked: assert property (@(posedge clk_i) disable iff (reset_i)
        mem.cmd_v |-> !mem.cmd_lock);
endmodule
`default_nettype wire

// File: tb/tb_bp_me_cce_block_to_dword_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_me_cce_block_to_dword_stream
// Description : Scoreboard bench with a dword-side adapter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_me_cce_block_to_dword_stream;
    logic clk = 1'b0;
    logic reset_i;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bp_me_cce_block_to_dword_stream_if #(.HDR_WIDTH(47), .DATA_WIDTH(512)) mem_if ();
    bp_me_cce_block_to_dword_stream_if #(.HDR_WIDTH(47), .DATA_WIDTH(64))  str_if ();

    bp_me_cce_block_to_dword_stream #(
        .PADDR_WIDTH(40), .BLOCK_WIDTH(512), .DWORD_WIDTH(64)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .mem     (mem_if),
        .stream  (str_if)
    );

    typedef struct packed { logic [46:0] hdr; logic [63:0] data; logic lock; } beat_t;
    typedef struct packed { logic [46:0] hdr; logic [511:0] data; } resp_t;

    beat_t exp_beat_q [$];
    beat_t src_q      [$];
    resp_t exp_resp_q [$];
    int issued, returned, txn_beats, resp_mode, ready_mode, pcnt;
    int last_resp_cyc = -1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [46:0] mk_hdr(input logic [3:0] mt, input logic [2:0] sz, input logic [39:0] a);
        return {mt, sz, a};
    endfunction

    function automatic logic [511:0] mk_block(input logic [63:0] base);
        logic [511:0] b;
        for (int i = 0; i < 8; i++) b[i*64 +: 64] = base | 64'(i);
        return b;
    endfunction

    // Dword-side adapter: backpressure pattern and response return timing per mode.
    initial begin
        logic took_cmd, took_resp, fire_now;
        int   avail;
        str_if.cmd_ready   = 1'b1;
        str_if.resp_v      = 1'b0;
        str_if.resp_header = '0;
        str_if.resp_data   = '0;
        str_if.resp_lock   = 1'b0;
        forever begin
            @(negedge clk);
            took_cmd  = str_if.cmd_v && str_if.cmd_ready;
            took_resp = str_if.resp_v && str_if.resp_yumi;
            @(posedge clk); #1;
            if (took_cmd) issued++;
            if (took_resp && src_q.size() > 0) begin
                void'(src_q.pop_front());
                returned++;
                if (returned == txn_beats) last_resp_cyc = cyc;
            end
            str_if.cmd_ready = (ready_mode == 0) || (pcnt % 3 == 0);
            pcnt++;
            fire_now = str_if.cmd_v && str_if.cmd_ready;
            avail = issued + ((resp_mode == 2 && fire_now) ? 1 : 0);
            if (src_q.size() > 0 && returned < avail && (resp_mode != 0 || issued == txn_beats)) begin
                str_if.resp_v      = 1'b1;
                str_if.resp_header = src_q[0].hdr;
                str_if.resp_data   = src_q[0].data;
                str_if.resp_lock   = src_q[0].lock;
            end else begin
                str_if.resp_v      = 1'b0;
            end
        end
    end

    // Beat monitor: a presented beat must equal the next expected one, held until taken.
    initial begin
        forever begin
            @(negedge clk);
            if (str_if.cmd_v) begin
                if (exp_beat_q.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    check("beat_header", str_if.cmd_header, exp_beat_q[0].hdr);
                    check("beat_data",   str_if.cmd_data,   exp_beat_q[0].data);
                    check("beat_lock",   str_if.cmd_lock,   exp_beat_q[0].lock);
                    if (str_if.cmd_ready) void'(exp_beat_q.pop_front());
                end
            end
        end
    end

    // Block response monitor.
    initial begin
        bit seen = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_if.resp_v) begin
                if (exp_resp_q.size() == 0) begin
                    check("resp_unexpected", 1, 0);
                end else begin
                    check("resp_header", mem_if.resp_header, exp_resp_q[0].hdr);
                    check("resp_data",   mem_if.resp_data,   exp_resp_q[0].data);
                    check("ready_during_resp", mem_if.cmd_ready, 0);
                    if (!seen) check("resp_latency", cyc, last_resp_cyc);
                    seen = 1'b1;
                    if (mem_if.resp_yumi) begin
                        void'(exp_resp_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic load_txn(input logic [3:0] mt, input logic [2:0] sz, input logic [39:0] addr,
                            input logic [511:0] cdata, input int n, input logic [39:0] baddr [8],
                            input logic [63:0] rbase, input int rmode, input int rdymode,
                            output logic [46:0] hdr);
        beat_t b;
        resp_t r;
        hdr = mk_hdr(mt, sz, addr);
        for (int i = 0; i < n; i++) begin
            b.hdr  = (n > 1) ? mk_hdr(mt, 3'd3, baddr[i]) : hdr;
            b.data = cdata[i*64 +: 64];
            b.lock = (i != n - 1);
            exp_beat_q.push_back(b);
            b.data = rbase | 64'(i);
            src_q.push_back(b);
        end
        r.hdr = hdr;
        for (int i = 0; i < 8; i++) r.data[i*64 +: 64] = (n == 1) ? rbase : (rbase | 64'(i));
        exp_resp_q.push_back(r);
        issued = 0; returned = 0; txn_beats = n; pcnt = 0;
        resp_mode = rmode; ready_mode = rdymode; last_resp_cyc = -1;
    endtask

    task automatic issue_cmd(input logic [46:0] hdr, input logic [511:0] cdata);
        int k;
        @(posedge clk); #1;
        mem_if.cmd_header = hdr;
        mem_if.cmd_data   = cdata;
        mem_if.cmd_v      = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mem_if.cmd_ready) break;
        end
        if (k == 50) check("cmd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        mem_if.cmd_v = 1'b0;
        @(negedge clk);
        check("beat0_latency", str_if.cmd_v, 1);
    endtask

    task automatic finish_txn(input int ydelay);
        int k;
        for (k = 0; k < 300; k++) begin
            if (mem_if.resp_v) break;
            @(negedge clk);
        end
        if (k == 300) begin
            check("resp_timeout", 0, 1);
            exp_beat_q.delete(); src_q.delete(); exp_resp_q.delete();
        end else begin
            repeat (ydelay) @(posedge clk);
            @(posedge clk); #1;
            mem_if.resp_yumi = 1'b1;
            @(posedge clk); #1;
            mem_if.resp_yumi = 1'b0;
            @(negedge clk);
            check("turnaround_ready", mem_if.cmd_ready, 1);
        end
        check("beats_left",  exp_beat_q.size(), 0);
        check("resps_owed",  src_q.size(), 0);
        check("blocks_left", exp_resp_q.size(), 0);
    endtask

    initial begin
        logic [39:0]  ba_rd [8];
        logic [39:0]  ba_wr [8];
        logic [39:0]  ba_one [8];
        logic [46:0]  hdr;
        logic [511:0] blk;

        ba_rd  = '{40'h0080000010, 40'h0080000018, 40'h0080000020, 40'h0080000028,
                   40'h0080000030, 40'h0080000038, 40'h0080000000, 40'h0080000008};
        ba_wr  = '{40'h0080001238, 40'h0080001200, 40'h0080001208, 40'h0080001210,
                   40'h0080001218, 40'h0080001220, 40'h0080001228, 40'h0080001230};
        ba_one = '{default: 40'h0080000004};

        reset_i = 1'b1;
        mem_if.cmd_v = 1'b0; mem_if.cmd_header = '0; mem_if.cmd_data = '0;
        mem_if.cmd_lock = 1'b0; mem_if.resp_yumi = 1'b0;
        resp_mode = 0; ready_mode = 0; issued = 0; returned = 0; txn_beats = 0; pcnt = 0;

        repeat (2) @(negedge clk);
        check("rst_cmd_ready",   mem_if.cmd_ready,   0);
        check("rst_resp_v",      mem_if.resp_v,      0);
        check("rst_resp_lock",   mem_if.resp_lock,   0);
        check("rst_beat_v",      str_if.cmd_v,       0);
        check("rst_beat_lock",   str_if.cmd_lock,    0);
        check("rst_resp_yumi",   str_if.resp_yumi,   0);
        check("rst_resp_header", mem_if.resp_header, 0);
        check("rst_resp_data",   mem_if.resp_data,   0);
        check("rst_beat_header", str_if.cmd_header,  0);
        check("rst_beat_data",   str_if.cmd_data,    0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("post_rst_ready", mem_if.cmd_ready, 1);

        // 64B read, critical word 2, responses after all beats.
        blk = mk_block(64'hC0DE_0000_0000_0000);
        load_txn(4'h0, 3'd6, 40'h0080000010, blk, 8, ba_rd, 64'hA5A5_0000_0000_0000, 0, 0, hdr);
        issue_cmd(hdr, blk);
        finish_txn(0);

        // 4B uncached write: one beat, address and size untouched, response replicated.
        blk = '0;
        blk[63:0] = 64'h0000_0000_DEAD_BEEF;
        load_txn(4'h3, 3'd2, 40'h0080000004, blk, 1, ba_one, 64'h0000_0000_DEAD_BEEF, 0, 0, hdr);
        issue_cmd(hdr, blk);
        finish_txn(0);

        // 64B write under 1,0,0 backpressure, wrapping from word 7.
        blk = mk_block(64'hBEEF_0000_0000_0000);
        load_txn(4'h3, 3'd6, 40'h0080001238, blk, 8, ba_wr, 64'h5500_0000_0000_0000, 1, 1, hdr);
        issue_cmd(hdr, blk);
        finish_txn(0);

        // Same read, responses one cycle behind each beat.
        blk = mk_block(64'hC0DE_0000_0000_0000);
        load_txn(4'h0, 3'd6, 40'h0080000010, blk, 8, ba_rd, 64'hA5A5_0000_0000_0000, 1, 0, hdr);
        issue_cmd(hdr, blk);
        finish_txn(0);

        // Response beat in the same cycle as its command beat; held response for 5 cycles.
        load_txn(4'h0, 3'd6, 40'h0080000010, blk, 8, ba_rd, 64'h7700_0000_0000_0000, 2, 0, hdr);
        issue_cmd(hdr, blk);
        finish_txn(5);

        // Asynchronous reset mid-transaction.
        load_txn(4'h0, 3'd6, 40'h0080000010, blk, 8, ba_rd, 64'hA5A5_0000_0000_0000, 1, 0, hdr);
        issue_cmd(hdr, blk);
        repeat (3) @(posedge clk);
        #3;
        reset_i = 1'b1;
        exp_beat_q.delete(); src_q.delete(); exp_resp_q.delete();
        #1;
        check("mid_rst_beat_v",    str_if.cmd_v,     0);
        check("mid_rst_beat_lock", str_if.cmd_lock,  0);
        check("mid_rst_resp_v",    mem_if.resp_v,    0);
        check("mid_rst_yumi",      str_if.resp_yumi, 0);
        check("mid_rst_ready",     mem_if.cmd_ready, 0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("mid_rst_ready_after", mem_if.cmd_ready, 1);

        // Recovery: single-beat write with a coincident response.
        blk = '0;
        blk[63:0] = 64'h0000_0000_DEAD_BEEF;
        load_txn(4'h3, 3'd2, 40'h0080000004, blk, 1, ba_one, 64'h1234_5678_9ABC_DEF0, 2, 0, hdr);
        issue_cmd(hdr, blk);
        finish_txn(0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: actual running required finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
